// File: rtl/mmio_uart_pkg.sv
// Shared definitions for mmio_uart: register offsets, STATUS bit indices,
// TX/RX state encodings and the divisor floor.
package mmio_uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_DIVISOR = 2'd3;

    localparam int ST_TXFULL   = 0;
    localparam int ST_RXVALID  = 1;
    localparam int ST_TXOVF    = 2;
    localparam int ST_RXOVF    = 3;
    localparam int ST_FERR     = 4;
    localparam int ST_IRQEN    = 5;
    localparam int ST_LOOPBACK = 6;

    localparam logic [15:0] MIN_DIVISOR = 16'd4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    function automatic logic [15:0] clamp_divisor(input logic [15:0] v);
        return (v < MIN_DIVISOR) ? MIN_DIVISOR : v;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-around pointers; the extra pointer MSB separates
// full from empty. Push+pop in the same cycle is honoured even when full/empty.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        do_push = push && (!full || pop);
        do_pop  = pop && (!empty || push);
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped FIFO-buffered 8N1 UART with registered one-cycle read data.
// Optional UART_LOOPBACK_EN adds STATUS[6] internal TX->RX loopback.
module mmio_uart
    import mmio_uart_pkg::*;
#(
    parameter int CLOCK_RATE = 12_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        wren,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam logic [15:0] RESET_DIV = 16'(CLOCK_RATE / BAUD_RATE);

    logic        wr_en, wr_tx, wr_rx, wr_status, wr_div;
    logic [15:0] div_q, div_d;
    logic        irqen_q, irqen_d, txovf_q, txovf_d, rxovf_q, rxovf_d, ferr_q, ferr_d;
    logic        irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d, status_w;
    logic        lb_bit;

    logic        tx_full, tx_empty, tx_pop;
    logic [7:0]  tx_head;
    logic        rx_full, rx_empty, rx_push, rx_ferr_evt, rx_sample_stop, rx_valid;
    logic [7:0]  rx_head;
    logic        rx_line;

    tx_state_e   tx_state_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [7:0]  tx_shift_q;
    logic [2:0]  tx_bit_q;
    logic        tx_q;

    rx_state_e   rx_state_q;
    logic [15:0] rx_cnt_q, rx_div_q;
    logic [7:0]  rx_shift_q;
    logic [2:0]  rx_bit_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;

    logic        unused_bits;
    assign unused_bits = ^{wdata[31:16], wmask[3:1]};

    assign wr_en     = sel && wren && wmask[0];
    assign wr_tx     = wr_en && (addr == REG_TXDATA);
    assign wr_rx     = wr_en && (addr == REG_RXDATA);
    assign wr_status = wr_en && (addr == REG_STATUS);
    assign wr_div    = wr_en && (addr == REG_DIVISOR);
    assign rx_valid  = !rx_empty;

    uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(wr_tx), .push_data(wdata[7:0]), .pop(tx_pop),
        .head(tx_head), .full(tx_full), .empty(tx_empty)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .push_data(rx_shift_q), .pop(wr_rx),
        .head(rx_head), .full(rx_full), .empty(rx_empty)
    );

`ifdef UART_LOOPBACK_EN
    logic loopback_q, loopback_d;
    assign lb_bit  = loopback_q;
    assign rx_line = loopback_q ? tx_q : rx_s2_q;
    assign uart_tx = tx_q | loopback_q;
`else
    assign lb_bit  = 1'b0;
    assign rx_line = rx_s2_q;
    assign uart_tx = tx_q;
`endif

    // TX pops when a frame starts, either from idle or straight out of STOP.
    assign tx_pop = !tx_empty && ((tx_state_q == TX_IDLE) ||
                                  (tx_state_q == TX_STOP && tx_cnt_q == 16'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= RESET_DIV;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_state_q <= TX_START;
                        tx_div_q   <= div_q;
                        tx_cnt_q   <= div_q - 16'd1;
                        tx_shift_q <= tx_head;
                        tx_q       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == 16'd0) begin
                        tx_state_q <= TX_DATA;
                        tx_cnt_q   <= tx_div_q - 16'd1;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == 16'd0) begin
                        tx_cnt_q <= tx_div_q - 16'd1;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_q       <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == 16'd0) begin
                        if (tx_pop) begin
                            tx_state_q <= TX_START;
                            tx_div_q   <= div_q;
                            tx_cnt_q   <= div_q - 16'd1;
                            tx_shift_q <= tx_head;
                            tx_q       <= 1'b0;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign rx_sample_stop = (rx_state_q == RX_STOP) && (rx_cnt_q == 16'd0);
    assign rx_push        = rx_sample_stop && rx_line;
    assign rx_ferr_evt    = rx_sample_stop && !rx_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= RESET_DIV;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
        end else begin
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_line;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_line) begin
                        rx_state_q <= RX_START;
                        rx_div_q   <= div_q;
                        rx_cnt_q   <= (div_q >> 1) - 16'd1;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == 16'd0) begin
                        if (rx_line) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_DATA;
                            rx_cnt_q   <= rx_div_q - 16'd1;
                            rx_bit_q   <= '0;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_shift_q <= {rx_line, rx_shift_q[7:1]};
                        rx_cnt_q   <= rx_div_q - 16'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == 16'd0) rx_state_q <= rx_line ? RX_IDLE : RX_WAIT_HIGH;
                    else                   rx_cnt_q   <= rx_cnt_q - 16'd1;
                end
                RX_WAIT_HIGH: begin
                    if (rx_line) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign status_w = {25'b0, lb_bit, irqen_q, ferr_q, rxovf_q, txovf_q, rx_valid, tx_full};

    always_comb begin
        div_d   = div_q;
        irqen_d = irqen_q;
        txovf_d = txovf_q;
        rxovf_d = rxovf_q;
        ferr_d  = ferr_q;
`ifdef UART_LOOPBACK_EN
        loopback_d = loopback_q;
`endif
        if (wr_status) begin
            if (wdata[ST_TXOVF]) txovf_d = 1'b0;
            if (wdata[ST_RXOVF]) rxovf_d = 1'b0;
            if (wdata[ST_FERR])  ferr_d  = 1'b0;
            irqen_d = wdata[ST_IRQEN];
`ifdef UART_LOOPBACK_EN
            loopback_d = wdata[ST_LOOPBACK];
`endif
        end
        if (wr_div) div_d = clamp_divisor(wdata[15:0]);
        // Error events are applied after W1C so a same-cycle event wins.
        if (wr_tx && tx_full && !tx_pop)  txovf_d = 1'b1;
        if (rx_push && rx_full && !wr_rx) rxovf_d = 1'b1;
        if (rx_ferr_evt)                  ferr_d  = 1'b1;

        irq_d = irqen_q && (rx_valid || rxovf_q || ferr_q);

        case (addr)
            REG_RXDATA:  rdata_d = {rx_valid, 23'b0, rx_valid ? rx_head : 8'h00};
            REG_STATUS:  rdata_d = status_w;
            REG_DIVISOR: rdata_d = {16'b0, div_q};
            default:     rdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= RESET_DIV;
            irqen_q <= 1'b0;
            txovf_q <= 1'b0;
            rxovf_q <= 1'b0;
            ferr_q  <= 1'b0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
`ifdef UART_LOOPBACK_EN
            loopback_q <= 1'b0;
`endif
        end else begin
            div_q   <= div_d;
            irqen_q <= irqen_d;
            txovf_q <= txovf_d;
            rxovf_q <= rxovf_d;
            ferr_q  <= ferr_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
`ifdef UART_LOOPBACK_EN
            loopback_q <= loopback_d;
`endif
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_mmio_uart.sv
// Self-checking bench for mmio_uart: randomized bytes checked against a
// queue-based reference of the serial protocol and register semantics.
module tb_mmio_uart;
    localparam int CLOCK_RATE = 12_000_000;
    localparam int BAUD_RATE  = 115200;
    localparam int DEPTH      = 16;
    localparam int DIV        = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0, wren = 1'b0;
    logic [3:0]  wmask = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] rdata;
    logic        uart_rx = 1'b1;
    logic        uart_tx, irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] tx_seen[$];
    bit   mon_en = 1'b0;
    logic irqen_m = 1'b0;

    always #5 clk = ~clk;

    mmio_uart #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE),
                .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sel(sel), .wren(wren), .wmask(wmask),
        .wdata(wdata), .addr(addr), .rdata(rdata),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    // Serial decoder on uart_tx: bit cells are DIV clocks, sampled mid-cell.
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx === 1'b0) begin
                repeat (DIV + DIV/2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    b[j] = uart_tx;
                    if (j < 7) repeat (DIV) @(negedge clk);
                end
                repeat (DIV) @(negedge clk);
                n_cmp++;
                if (uart_tx !== 1'b1) begin
                    n_bad++;
                    $display("FAIL tx_stop_bit: got %b want 1", uart_tx);
                end
                tx_seen.push_back(b);
                repeat (DIV - DIV/2 - 1) @(negedge clk);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_status(input logic txfull, input logic rxvalid,
                                               input logic txovf, input logic rxovf,
                                               input logic ferr);
        return {26'b0, irqen_m, ferr, rxovf, txovf, rxvalid, txfull};
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d,
                             input logic [3:0] m = 4'h1);
        @(negedge clk);
        sel = 1'b1; wren = 1'b1; wmask = m; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; wren = 1'b0; wmask = 4'h0; wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wren = 1'b0; addr = a;
        @(negedge clk);
        d = rdata;
        sel = 1'b0;
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            uart_rx = b[j];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        rst = 1'b0;
        bus_read(2'd2, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h want 0", d); end
        bus_read(2'd3, d);
        n_cmp++; if (d !== 32'(CLOCK_RATE / BAUD_RATE)) begin
            n_bad++; $display("FAIL reset_divisor: got %0d want %0d", d, CLOCK_RATE / BAUD_RATE);
        end
        bus_read(2'd1, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_rxdata: got %h want 0", d); end
    endtask

    task automatic test_divisor;
        logic [31:0] d;
        logic [15:0] r;
        bus_write(2'd3, 32'd2);
        bus_read(2'd3, d);
        n_cmp++; if (d !== 32'd4) begin n_bad++; $display("FAIL div_clamp2: got %0d want 4", d); end
        bus_write(2'd3, 32'd0);
        bus_read(2'd3, d);
        n_cmp++; if (d !== 32'd4) begin n_bad++; $display("FAIL div_clamp0: got %0d want 4", d); end
        r = 16'($urandom_range(4, 65535));
        bus_write(2'd3, {16'hBEEF, r});
        bus_read(2'd3, d);
        n_cmp++; if (d !== {16'h0, r}) begin n_bad++; $display("FAIL div_rw: got %0d want %0d", d, r); end
        bus_write(2'd3, 32'd77, 4'hE);
        bus_read(2'd3, d);
        n_cmp++; if (d !== {16'h0, r}) begin n_bad++; $display("FAIL div_wmask: got %0d want %0d", d, r); end
        bus_write(2'd3, DIV);
    endtask

    task automatic test_tx_frame;
        logic [7:0] b;
        logic [7:0] exp_q[$];
        logic       e;
        bit         ok;
        tx_seen.delete();
        mon_en = 1'b1;
        b = 8'hA5;
        bus_write(2'd0, {24'h0, b});
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL tx_latency_idle: got %b want 1", uart_tx); end
        @(negedge clk);
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (i < DIV)            e = 1'b0;
            else if (i < 9 * DIV)   e = b[(i - DIV) / DIV];
            else                    e = 1'b1;
            if (uart_tx !== e) begin
                ok = 1'b0;
                $display("FAIL tx_wave cycle %0d: got %b want %b", i, uart_tx, e);
            end
        end
        n_cmp++; if (!ok) n_bad++;
        @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL tx_idle_after: got %b want 1", uart_tx); end
        repeat (4) @(negedge clk);
        exp_q.push_back(b);
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            bus_write(2'd0, {24'h0, b});
        end
        for (int t = 0; t < 400 && tx_seen.size() < 4; t++) @(negedge clk);
        n_cmp++; if (tx_seen.size() != 4) begin
            n_bad++; $display("FAIL tx_count: got %0d want 4", tx_seen.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if (tx_seen[k] !== exp_q[k]) begin
                    n_bad++; $display("FAIL tx_byte%0d: got %h want %h", k, tx_seen[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_tx_overflow;
        logic [7:0]  exp_q[$];
        logic [7:0]  b;
        logic [31:0] d;
        tx_seen.delete();
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(2'd0, {24'h0, b});
        repeat (3) @(negedge clk);
        for (int k = 0; k < DEPTH + 1; k++) begin
            b = 8'($urandom);
            if (k < DEPTH) exp_q.push_back(b);
            @(negedge clk);
            sel = 1'b1; wren = 1'b1; wmask = 4'h1; addr = 2'd0; wdata = {24'h0, b};
        end
        @(negedge clk);
        sel = 1'b0; wren = 1'b0; wmask = 4'h0;
        bus_read(2'd2, d);
        n_cmp++; if (d !== exp_status(1'b1, 1'b0, 1'b1, 1'b0, 1'b0)) begin
            n_bad++; $display("FAIL txovf_status: got %h want %h", d, exp_status(1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        for (int t = 0; t < (DEPTH + 2) * 40 + 200 && tx_seen.size() < DEPTH + 1; t++) @(negedge clk);
        repeat (60) @(negedge clk);
        n_cmp++; if (tx_seen.size() != exp_q.size()) begin
            n_bad++; $display("FAIL txovf_count: got %0d want %0d", tx_seen.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_cmp++; if (tx_seen[k] !== exp_q[k]) begin
                    n_bad++; $display("FAIL txovf_byte%0d: got %h want %h", k, tx_seen[k], exp_q[k]);
                end
            end
        end
        bus_write(2'd2, {26'h0, irqen_m, 5'b00100});
        bus_read(2'd2, d);
        n_cmp++; if (d !== exp_status(1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_bad++; $display("FAIL txovf_w1c: got %h want %h", d, exp_status(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        mon_en = 1'b0;
    endtask

    task automatic test_rx;
        logic [7:0]  b;
        logic [31:0] d;
        logic [7:0]  q[$];
        bus_write(2'd2, 32'h20);
        irqen_m = 1'b1;
        b = 8'h3C;
        drive_rx_frame(b, 1'b1);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL rx_irq: got %b want 1", irq); end
        @(negedge clk);
        sel = 1'b0; addr = 2'd2;
        @(negedge clk);
        n_cmp++; if (rdata !== exp_status(1'b0, 1'b1, 1'b0, 1'b0, 1'b0)) begin
            n_bad++; $display("FAIL rx_status: got %h want %h", rdata, exp_status(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        addr = 2'd1;
        #1;
        n_cmp++; if (rdata !== exp_status(1'b0, 1'b1, 1'b0, 1'b0, 1'b0)) begin
            n_bad++; $display("FAIL rdata_latency: got %h want %h", rdata, exp_status(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        @(negedge clk);
        n_cmp++; if (rdata !== {1'b1, 23'h0, b}) begin
            n_bad++; $display("FAIL rx_data: got %h want %h", rdata, {1'b1, 23'h0, b});
        end
        bus_write(2'd1, $urandom);
        bus_read(2'd1, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rx_pop_empty: got %h want 0", d); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rx_irq_clear: got %b want 0", irq); end
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            q.push_back(b);
            drive_rx_frame(b, 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            bus_read(2'd1, d);
            n_cmp++; if (d !== {1'b1, 23'h0, q[k]}) begin
                n_bad++; $display("FAIL rx_multi%0d: got %h want %h", k, d, {1'b1, 23'h0, q[k]});
            end
            bus_write(2'd1, 32'h0);
        end
    endtask

    task automatic test_rx_overflow;
        logic [7:0]  q[$];
        logic [7:0]  b;
        logic [31:0] d;
        for (int k = 0; k < DEPTH + 1; k++) begin
            b = 8'($urandom);
            if (k < DEPTH) q.push_back(b);
            drive_rx_frame(b, 1'b1);
        end
        bus_read(2'd2, d);
        n_cmp++; if (d !== exp_status(1'b0, 1'b1, 1'b0, 1'b1, 1'b0)) begin
            n_bad++; $display("FAIL rxovf_status: got %h want %h", d, exp_status(1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        end
        for (int k = 0; k < DEPTH; k++) begin
            bus_read(2'd1, d);
            n_cmp++; if (d !== {1'b1, 23'h0, q[k]}) begin
                n_bad++; $display("FAIL rxovf_byte%0d: got %h want %h", k, d, {1'b1, 23'h0, q[k]});
            end
            bus_write(2'd1, 32'h0);
        end
        bus_write(2'd2, 32'h28);
        bus_read(2'd2, d);
        n_cmp++; if (d !== exp_status(1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_bad++; $display("FAIL rxovf_w1c: got %h want %h", d, exp_status(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_ferr;
        logic [7:0]  b;
        logic [31:0] d;
        bus_write(2'd2, 32'h0);
        irqen_m = 1'b0;
        drive_rx_frame(8'($urandom), 1'b0);
        bus_read(2'd2, d);
        n_cmp++; if (d !== exp_status(1'b0, 1'b0, 1'b0, 1'b0, 1'b1)) begin
            n_bad++; $display("FAIL ferr_set: got %h want %h", d, exp_status(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL ferr_irq_masked: got %b want 0", irq); end
        bus_write(2'd2, 32'h10);
        bus_read(2'd2, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL ferr_w1c: got %h want 0", d); end
        b = 8'($urandom);
        drive_rx_frame(b, 1'b1);
        bus_read(2'd1, d);
        n_cmp++; if (d !== {1'b1, 23'h0, b}) begin
            n_bad++; $display("FAIL ferr_recover: got %h want %h", d, {1'b1, 23'h0, b});
        end
        bus_write(2'd1, 32'h0);
    endtask

    task automatic test_glitch;
        logic [7:0]  b;
        logic [31:0] d;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(2'd2, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL glitch_status: got %h want 0", d); end
        b = 8'($urandom);
        drive_rx_frame(b, 1'b1);
        bus_read(2'd1, d);
        n_cmp++; if (d !== {1'b1, 23'h0, b}) begin
            n_bad++; $display("FAIL glitch_recover: got %h want %h", d, {1'b1, 23'h0, b});
        end
        bus_write(2'd1, 32'h0);
    endtask

    task automatic test_loopback;
        logic [31:0] d;
        bit          hi;
        bus_write(2'd2, 32'h40);
`ifdef UART_LOOPBACK_EN
        bus_read(2'd2, d);
        n_cmp++; if (d !== 32'h40) begin n_bad++; $display("FAIL lb_status: got %h want 40", d); end
        bus_write(2'd0, 32'h5A);
        hi = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) hi = 1'b0;
        end
        n_cmp++; if (!hi) begin n_bad++; $display("FAIL lb_pin_high: got 0 want 1"); end
        bus_read(2'd1, d);
        n_cmp++; if (d !== 32'h8000005A) begin n_bad++; $display("FAIL lb_rxdata: got %h want 8000005a", d); end
        bus_write(2'd1, 32'h0);
        bus_write(2'd2, 32'h0);
`else
        hi = 1'b1;
        bus_read(2'd2, d);
        n_cmp++; if (d !== 32'h0 || !hi) begin n_bad++; $display("FAIL lb_absent: got %h want 0", d); end
`endif
    endtask

    task automatic test_reset_midframe;
        mon_en = 1'b0;
        bus_write(2'd0, 32'h00);
        repeat (10) @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL midframe_low: got %b want 0", uart_tx); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL midframe_abort: got %b want 1", uart_tx); end
        rst = 1'b0;
        irqen_m = 1'b0;
        repeat (60) @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL midframe_idle: got %b want 1", uart_tx); end
    endtask

    initial begin
        test_reset();
        test_divisor();
        test_tx_frame();
        test_tx_overflow();
        test_rx();
        test_rx_overflow();
        test_ferr();
        test_glitch();
        test_loopback();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
